// File: rtl/aes_pkg.sv
// Shared AES types plus the coefficient select/rotate used by the iterative InvMixColumns engine.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mcinv_state_e;

    localparam int MCINV_BYTES = 16;

    // prod holds {e*x, 9*x, d*x, b*x}; byte j of the result gets the product
    // for inverse-matrix entry (row - j) mod 4 in the order e, b, d, 9.
    function automatic aes_word_t mcinv_contrib(input aes_word_t prod, input logic [1:0] row);
        logic [7:0] coef [4];
        logic [1:0] sel;
        aes_word_t  res;
        coef[0] = prod[31:24];
        coef[1] = prod[7:0];
        coef[2] = prod[15:8];
        coef[3] = prod[23:16];
        res = '0;
        for (int j = 0; j < 4; j++) begin
            sel = row - 2'(j);
            res[8*j +: 8] = coef[sel];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_mixcolumn_byte_inv.sv
// Multiplies one state byte by the four InvMixColumns coefficients in GF(2^8).
// Purely combinational; out_word = {e*x, 9*x, d*x, b*x}.
module aes_mixcolumn_byte_inv (
    input  logic [7:0]  in_byte,
    output logic [31:0] out_word
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;

    always_comb begin
        x2 = xtime(in_byte);
        x4 = xtime(x2);
        x8 = xtime(x4);
        out_word[31:24] = x8 ^ x4 ^ x2;
        out_word[23:16] = x8 ^ in_byte;
        out_word[15:8]  = x8 ^ x4 ^ in_byte;
        out_word[7:0]   = x8 ^ x2 ^ in_byte;
    end

endmodule

// File: rtl/aes_mixcolumn_state_inv_iter.sv
// Iterative InvMixColumns over a 128-bit state: one byte per cycle, 16 cycles per state,
// valid/ready on both sides with no overlap between output drain and the next accept.
module aes_mixcolumn_state_inv_iter
    import aes_pkg::*;
#(
    parameter int STATE_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
);

    mcinv_state_e state_q, state_d;
    logic [3:0]   count_q, count_d;
    aes_state_t   src_q, src_d;
    aes_word_t    acc_q, acc_d;
    aes_state_t   result_q, result_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;

    logic [7:0]   cur_byte;
    aes_word_t    prod;
    aes_word_t    col_word;

    assign cur_byte = src_q[{count_q, 3'b000} +: 8];

    aes_mixcolumn_byte_inv u_byte_inv (
        .in_byte  (cur_byte),
        .out_word (prod)
    );

    assign col_word = acc_q ^ mcinv_contrib(prod, count_q[1:0]);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        src_d    = src_q;
        acc_d    = acc_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    src_d   = in_state;
                    count_d = 4'd0;
                    acc_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                count_d = count_q + 4'd1;
                // Last row of a column completes it; the accumulator restarts for the next one.
                if (count_q[1:0] == 2'd3) begin
                    result_d[{count_q[3:2], 5'b00000} +: 32] = col_word;
                    acc_d = '0;
                end else begin
                    acc_d = col_word;
                end
                if (count_q == 4'(MCINV_BYTES - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            count_d = 4'd0;
            acc_d   = '0;
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= 4'd0;
            src_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            src_q       <= src_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = result_q;

endmodule

// File: tb/tb_aes_mixcolumn_state_inv_iter.sv
// Directed and randomized checks of the iterative InvMixColumns engine against a GF(2^8) matrix model.
module tb_aes_mixcolumn_state_inv_iter;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    int n_checks = 0;
    int n_errors = 0;

    aes_mixcolumn_state_inv_iter #(.STATE_W(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Textbook shift-and-add GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input int a, input int b);
        int p  = 0;
        int aa = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) != 0) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
        end
        return 8'(p);
    endfunction

    // Column-wise matrix product; the matrix is circulant with first row base[0..3].
    function automatic logic [127:0] mix(input logic [127:0] s, input bit inverse);
        int base [4];
        logic [127:0] r = '0;
        int acc;
        if (inverse) begin
            base[0] = 'h0e; base[1] = 'h0b; base[2] = 'h0d; base[3] = 'h09;
        end else begin
            base[0] = 2; base[1] = 3; base[2] = 1; base[3] = 1;
        end
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 0;
                for (int i = 0; i < 4; i++)
                    acc = acc ^ int'(gmul(base[(i - row + 4) % 4], int'(s[8*(4*c+i) +: 8])));
                r[8*(4*c+row) +: 8] = 8'(acc);
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] s);
        int n = 0;
        in_valid = 1'b1;
        in_state = s;
        while (!in_ready && n < 64) begin
            tick();
            n++;
        end
        chk("accept_wait", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        in_state = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [127:0] s, exp_s, held;
    logic [127:0] exp_q [$];
    int lat, gap, n_out;
    bit seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_state = '0; flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 128'(in_ready), 128'd1);

        // Single column, exact latency
        s = {32'h01010101, 32'h01010101, 32'h01010101, 32'hbca14d8e};
        send(s);
        wait_out(lat);
        chk("col_latency", 128'(lat), 128'd16);
        chk("col_result", out_state, {32'h01010101, 32'h01010101, 32'h01010101, 32'h455313db});
        drain();
        chk("col_drain_in_ready", 128'(in_ready), 128'd1);
        chk("col_drain_out_valid", 128'(out_valid), 128'd0);

        // Full state, then 10 cycles of backpressure
        s = {32'h9d58dc9f, 32'hc6c6c6c6, 32'hbca14d8e, 32'h01010101};
        exp_s = {32'h5c220af2, 32'hc6c6c6c6, 32'h455313db, 32'h01010101};
        send(s);
        wait_out(lat);
        chk("full_latency", 128'(lat), 128'd16);
        chk("full_result", out_state, exp_s);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_out_state", out_state, exp_s);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
        end
        drain();
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        chk("bp_release_out_valid", 128'(out_valid), 128'd0);

        // Flush while count is 7
        send({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 7; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_in_ready", 128'(in_ready), 128'd1);
        chk("flush_out_valid", 128'(out_valid), 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_output", 128'(seen), 128'd0);
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s);
        wait_out(lat);
        chk("post_flush_latency", 128'(lat), 128'd16);
        chk("post_flush_result", out_state, mix(s, 1'b1));
        drain();

        // Reset during BUSY
        send({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        chk("rst_busy_in_ready", 128'(in_ready), 128'd0);
        chk("rst_busy_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy_out_state", out_state, 128'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("rst_busy_no_output", 128'(seen), 128'd0);

        // Reset during DONE
        send({$urandom, $urandom, $urandom, $urandom});
        wait_out(lat);
        chk("pre_rst_done_valid", 128'(out_valid), 128'd1);
        rst = 1'b1;
        tick();
        chk("rst_done_out_valid", 128'(out_valid), 128'd0);
        chk("rst_done_out_state", out_state, 128'd0);
        chk("rst_done_in_ready", 128'(in_ready), 128'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        chk("rst_done_no_output", 128'(seen), 128'd0);
        chk("rst_done_recover_in_ready", 128'(in_ready), 128'd1);

        // Randomized back-to-back traffic
        n_out = 0;
        for (int t = 0; t < 100; t++) begin
            gap = $urandom_range(0, 3);
            for (int i = 0; i < gap; i++) tick();
            s = {$urandom, $urandom, $urandom, $urandom};
            send(s);
            exp_q.push_back(s);
            out_ready = 1'($urandom_range(0, 1));
            wait_out(lat);
            chk("rnd_latency", 128'(lat), 128'd16);
            gap = $urandom_range(0, 4);
            out_ready = 1'b0;
            for (int i = 0; i < gap; i++) tick();
            held = out_state;
            if (exp_q.size() != 0) begin
                s = exp_q.pop_front();
                chk("rnd_result", held, mix(s, 1'b1));
                chk("rnd_roundtrip", mix(held, 1'b0), s);
            end
            drain();
            n_out++;
            chk("rnd_single_output", 128'(out_valid), 128'd0);
        end
        chk("rnd_outputs", 128'(n_out), 128'd100);
        chk("rnd_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
